// File: rtl/piso_bit_sender.sv
// ---------------------------------------------------------------------------
// piso_bit_sender
//   Parallel-in, serial-out transmitter. A WIDTH-bit word is accepted through
//   a load/ready handshake and presented one bit at a time on d_out. Each bit
//   is held stable until shift_en advances it, so a load-gated single-bit
//   capture stage downstream can sample it at its own pace.
//
// Parameters
//   WIDTH      word length in bits (2..32)
//   MSB_FIRST  1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   load      accept data_in (honoured only while ready=1)
//   data_in   parallel word, sampled on the accepting edge
//   shift_en  advance to the next bit (only meaningful while busy)
//   ready     high while idle (combinational from state)
//   d_out     current serial bit (registered)
//   busy      high while bits are being presented (combinational from state)
//   done      one-cycle pulse after the last bit is retired (registered)
// ---------------------------------------------------------------------------
module piso_bit_sender #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_en,
  output logic             ready,
  output logic             d_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  // Bit positions at the output end of the shift register: the first bit of
  // a fresh word, and the bit that becomes current after one advance.
  localparam int FIRST_IDX = MSB_FIRST ? WIDTH - 1 : 0;
  localparam int NEXT_IDX  = MSB_FIRST ? WIDTH - 2 : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg,  sreg_nx;
  logic [CW-1:0]    cnt,   cnt_nx;
  logic             d_out_nx;
  logic             done_nx;
  logic [WIDTH-1:0] sreg_shifted;

  // Move one place toward the output end; zeros fill the far end.
  assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                                  : {1'b0, sreg[WIDTH-1:1]};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nx = state;
    sreg_nx  = sreg;
    cnt_nx   = cnt;
    d_out_nx = d_out;
    done_nx  = 1'b0;

    case (state)
      IDLE: begin
        if (load) begin
          sreg_nx  = data_in;
          d_out_nx = data_in[FIRST_IDX];
          cnt_nx   = '0;
          state_nx = SHIFT;
        end
      end

      SHIFT: begin
        if (shift_en) begin
          if (cnt == LAST_CNT) begin
            // Last bit retired: d_out, register and counter stay as they are.
            state_nx = DONE;
            done_nx  = 1'b1;
          end else begin
            sreg_nx  = sreg_shifted;
            d_out_nx = sreg[NEXT_IDX];
            cnt_nx   = cnt + CW'(1);
          end
        end
      end

      DONE: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // sees the pre-edge value of every other register.
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      d_out <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      sreg  <= sreg_nx;
      cnt   <= cnt_nx;
      d_out <= d_out_nx;
      done  <= done_nx;
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == SHIFT);

endmodule

// File: tb/tb_piso_bit_sender.sv
// ---------------------------------------------------------------------------
// tb_piso_bit_sender
//   Drives two instances (MSB-first and LSB-first) from the same stimulus.
//   A word-level reference model queues each accepted word and tracks which
//   bit of it should be on the wire; a monitor compares both instances to the
//   model every cycle on the falling edge.
// ---------------------------------------------------------------------------
module tb_piso_bit_sender;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] data_in;
  logic         shift_en;

  logic m_ready, m_d_out, m_busy, m_done;
  logic l_ready, l_d_out, l_busy, l_done;

  always #5 clk = ~clk;

  piso_bit_sender #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data_in  (data_in),
    .shift_en (shift_en),
    .ready    (m_ready),
    .d_out    (m_d_out),
    .busy     (m_busy),
    .done     (m_done)
  );

  piso_bit_sender #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data_in  (data_in),
    .shift_en (shift_en),
    .ready    (l_ready),
    .d_out    (l_d_out),
    .busy     (l_busy),
    .done     (l_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model: words in flight, index of the bit on the wire, pending
  // done cycle, and the bit each orientation should currently show.
  // ------------------------------------------------------------------------
  logic [W-1:0] words_q[$];
  int           bit_idx   = 0;
  bit           done_pend = 1'b0;
  logic         exp_m     = 1'b0;
  logic         exp_l     = 1'b0;
  bit           started   = 1'b0;

  initial begin
    logic [W-1:0] retired;
    forever begin
      @(posedge clk);
      if (rst) begin
        words_q.delete();
        bit_idx   = 0;
        done_pend = 1'b0;
        exp_m     = 1'b0;
        exp_l     = 1'b0;
        started   = 1'b1;
      end else if (done_pend) begin
        done_pend = 1'b0;
      end else if (words_q.size() == 0) begin
        if (load) begin
          words_q.push_back(data_in);
          bit_idx = 0;
          exp_m   = data_in[W-1];
          exp_l   = data_in[0];
        end
      end else if (shift_en) begin
        if (bit_idx == W - 1) begin
          retired   = words_q.pop_front();
          done_pend = 1'b1;
        end else begin
          bit_idx = bit_idx + 1;
          exp_m   = words_q[0][W-1-bit_idx];
          exp_l   = words_q[0][bit_idx];
        end
      end
    end
  end

  // Monitor: compare both instances against the model away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("msb_d_out", m_d_out, exp_m);
        check("lsb_d_out", l_d_out, exp_l);
        check("msb_busy",  m_busy,  words_q.size() != 0);
        check("lsb_busy",  l_busy,  words_q.size() != 0);
        check("msb_ready", m_ready, (words_q.size() == 0) && !done_pend);
        check("lsb_ready", l_ready, (words_q.size() == 0) && !done_pend);
        check("msb_done",  m_done,  done_pend);
        check("lsb_done",  l_done,  done_pend);
      end
    end
  end

  // One clock of stimulus; inputs change just after the falling edge.
  task automatic step(input logic r, input logic l, input logic [W-1:0] d,
                      input logic s);
    rst      = r;
    load     = l;
    data_in  = d;
    shift_en = s;
    @(negedge clk);
    #1;
  endtask

  task automatic idle_shift(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    // Reset with load asserted: nothing may be captured.
    step(1'b1, 1'b1, 8'hFF, 1'b0);
    step(1'b1, 1'b1, 8'hFF, 1'b0);

    // Straight word, shift_en held high.
    step(1'b0, 1'b1, 8'hA5, 1'b1);
    idle_shift(11);

    // Stall for five cycles after the load, then run.
    step(1'b0, 1'b1, 8'h3C, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b0);
    idle_shift(10);

    // Load with a different word while busy must be ignored.
    step(1'b0, 1'b1, 8'hF0, 1'b1);
    idle_shift(3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h0F, 1'b1);
    idle_shift(6);

    // Reset mid-word, then a fresh word.
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    idle_shift(2);
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 8'h81, 1'b1);
    idle_shift(10);

    // Back-to-back words with load held high.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h80, 1'b1);
    idle_shift(3);

    // Randomized traffic, including occasional resets and stalls.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 2) == 0,
           W'($urandom),
           $urandom_range(0, 3) != 0);
    end
    idle_shift(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_bit_sender.md
Name: piso_bit_sender

Overview:
- Parallel-in, serial-out transmitter: the sending end for a load-gated single-bit capture stage.
- Accepts a WIDTH-bit word through a load/ready handshake and presents it one bit per enabled clock on d_out.
- Holds each bit stable between advances, so a downstream load-gated latch can capture it.
- Reports busy while sending and a one-cycle done pulse at the end of each word.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = send bit WIDTH-1 first; 0 = send bit 0 first.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  request to accept data_in; honoured only when ready=1.
- data_in  input  WIDTH  parallel word, sampled on the accepting edge.
- shift_en  input  1  advance to the next bit; ignored outside SHIFT.
- ready  output  1  high in IDLE only; combinational decode of state.
- d_out  output  1  current serial bit; registered.
- busy  output  1  high in SHIFT; combinational decode of state.
- done  output  1  one-cycle pulse after the last bit is retired; registered.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, shift register=0, bit counter=0, d_out=0, done=0.
  - Reset has priority over load and shift_en.
  - Reset mid-word aborts the word; no done pulse is generated.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1, busy=0.
  - On an edge with load=1: capture data_in into the shift register, set d_out to the first bit (data_in[WIDTH-1] if MSB_FIRST, else data_in[0]), clear the counter, go to SHIFT.
  - d_out is valid on the cycle after the load edge: 1-cycle latency.
  - With load=0, d_out holds its last value.
- SHIFT:
  - ready=0, busy=1.
  - Edge with shift_en=0: nothing changes; d_out holds, with no limit on stall length.
  - Edge with shift_en=1 and counter<WIDTH-1: shift the register one place toward the output end, d_out=next bit, counter+1.
  - Edge with shift_en=1 and counter=WIDTH-1: last bit retired; go to DONE and set done=1.
  - d_out keeps the last bit; the register and counter are unchanged.
  - load is ignored in SHIFT: data_in is not sampled and the word in flight is not corrupted.
- DONE: lasts exactly one cycle.
  - done=1, ready=0, busy=0.
  - Next edge goes unconditionally to IDLE with done=0.
  - load is ignored in DONE; the earliest next accept is the edge after DONE.
- Bit count: exactly WIDTH bits are presented, each for 1+(stall cycles) clocks.
  - The first bit needs no shift_en; WIDTH-1 advances plus one retiring shift_en complete the word.
- Shift register fill: zeros enter at the far end. This is not observable on d_out.
- Counter width: clog2(WIDTH), no wrap. Counter comparison uses WIDTH-1 exactly.
- Back-to-back words: load held high gives one word every WIDTH+2 cycles with shift_en tied high (1 accept, WIDTH-1 advances, 1 retire, 1 DONE).

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with load=1, data_in=8'hFF.
  - Response: d_out=0, ready=1, busy=0, done=0; no capture occurs.
- MSB-first word (WIDTH=8, MSB_FIRST=1):
  - Stimulus: load 8'hA5, shift_en held 1.
  - Response: d_out over successive cycles = 1,0,1,0,0,1,0,1; done=1 exactly one cycle after the eighth bit; ready back to 1 on the following cycle.
- Stall/hold:
  - Stimulus: load 8'h3C, shift_en=0 for 5 cycles after the load, then 1.
  - Response: d_out=0 held for all 6 cycles; then the sequence continues 0,1,1,1,1,0,0 with no bit skipped.
- Load ignored while busy:
  - Stimulus: load 8'hF0; at bit 3 assert load with data_in=8'h0F.
  - Response: the remaining bits still follow 8'hF0; ready stays 0 until after done.
- Reset mid-word:
  - Stimulus: load 8'hFF; assert rst after 3 bits.
  - Response: next cycle d_out=0, state IDLE, done never pulses; a subsequent load of 8'h81 sends 1,0,0,0,0,0,0,1.
- LSB-first and back-to-back (MSB_FIRST=0):
  - Stimulus: load held 1, data_in=8'h01 then 8'h80, shift_en=1.
  - Response: words 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1; accepts 10 cycles apart; one done pulse per word.
